posit_result_fifo: RTL and testbench
====================================

// Module: posit_result_fifo
// PURPOSE
//   Multi-channel result buffer for the posit coprocessor: one circular FIFO per arithmetic unit
//   (add/mul/div/...), filled by unit done/out pulses, drained by bus reads from the coprocessor front end.
//   Blocking reads: a read of an empty channel stays pending until a result arrives.
//   Adds overflow detection, full/empty status and a parametrised width/depth/channel count.
// PARAMETERS
//   DATA_W  32  result word width (bits)
//   DEPTH   32  entries per channel; power of two, >= 2
//   NUM_CH  3   number of independent channels (one per arithmetic unit), 1..8
//   CH_W    $clog2(NUM_CH)>0 ? $clog2(NUM_CH) : 1  (derived, localparam) channel index width
// PORTS
//   clk_i          in   1              clock; all state on rising edge
//   rst_i          in   1              asynchronous reset, active-high
//   push_i         in   NUM_CH         per-channel write strobe (unit done pulse)
//   push_data_i    in   NUM_CH*DATA_W  per-channel result; channel c at [c*DATA_W +: DATA_W]
//   rd_req_i       in   1              read request strobe (one cycle)
//   rd_ch_i        in   CH_W           channel selected by rd_req_i
//   rd_valid_o     out  1              one-cycle pulse: rd_data_o/rd_err_o valid
//   rd_data_o      out  DATA_W         read data; 0 whenever rd_valid_o=0
//   rd_err_o       out  1              read completed with error (bad channel or flushed); qualified by rd_valid_o
//   rd_busy_o      out  1              a read is pending; new rd_req_i ignored
//   empty_o        out  NUM_CH         channel holds 0 entries
//   full_o         out  NUM_CH         channel holds DEPTH entries
//   overflow_o     out  NUM_CH         sticky: a push was dropped on this channel
//   flush_i        in   NUM_CH         [POSIT_FIFO_FLUSH_EN only] per-channel clear strobe
// BEHAVIOUR
//   Reset: all pointers 0, all channels empty; rd_valid_o=0, rd_data_o=0, rd_err_o=0, rd_busy_o=0,
//     empty_o=all 1, full_o=0, overflow_o=0. Reset mid-read drops the pending read, no rd_valid_o pulse.
//   Storage: per channel, wr/rd pointers of $clog2(DEPTH)+1 bits; index = low bits, wrap DEPTH-1 -> 0;
//     empty when ptrs equal, full when indices equal and MSBs differ. count = wr-rd (mod 2*DEPTH).
//   Push: push_i[c]=1 and not full -> store word, wr_ptr+1; visible to reads next cycle.
//     Push on full with no pop on c the same cycle -> word dropped, overflow_o[c] set (sticky to reset/flush).
//     Push on full with simultaneous pop on c -> accepted, count unchanged, no overflow.
//   Read FSM (single outstanding read): IDLE, PEND.
//     IDLE, rd_req_i, rd_ch_i>=NUM_CH -> next cycle rd_valid_o=1, rd_err_o=1, rd_data_o=0; stay IDLE.
//     IDLE, rd_req_i, channel non-empty -> pop head; next cycle rd_valid_o=1, rd_data_o=head; stay IDLE.
//     IDLE, rd_req_i, channel empty (push same cycle not counted) -> PEND, latch channel, rd_busy_o=1 next cycle.
//     PEND: first cycle latched channel is non-empty -> pop head; next cycle rd_valid_o=1 with head, -> IDLE.
//       Minimum latency from push into empty pended channel to rd_valid_o: 2 cycles.
//     rd_req_i while PEND: ignored entirely (no pulse, no state change).
//   Latency of hit read: rd_valid_o exactly 1 cycle after rd_req_i. Ordering strictly FIFO per channel.
//   Channels independent: simultaneous pushes on all channels plus one pop all complete in one cycle.
//   empty_o/full_o/overflow_o are registered state, updated same edge as pointers.
// CONFIGURATION
//   POSIT_FIFO_FLUSH_EN defined: flush_i port present. flush_i[c]=1 -> next cycle channel c empty,
//     overflow_o[c]=0; flush wins over push/pop on c the same cycle. A pending read on c is cancelled:
//     next cycle rd_valid_o=1, rd_err_o=1, rd_data_o=0, FSM -> IDLE.
//   Not defined: flush_i port absent; channels cleared only by rst_i.
// TESTING
//   T1 push 0x3F800001 on ch0; 2 cyc later rd_req_i ch0 -> rd_valid_o next cyc, data 0x3F800001, empty_o[0]=1.
//   T2 read ch1 empty -> rd_busy_o=1, no valid; push 0x12345678 ch1 at cycle t -> rd_valid_o at t+2, data match.
//   T3 push DEPTH+1 words ch2 (0..32) -> full_o[2]=1, overflow_o[2]=1; 32 reads return 0..31 in order, wrap ok.
//   T4 rd_req_i rd_ch_i=3 (NUM_CH=3) -> next cycle rd_valid_o=1, rd_err_o=1, rd_data_o=0.
//   T5 ch0 full; push+pop same cycle -> overflow_o[0]=0, count stays DEPTH, new word read last.
//   T6 (FLUSH_EN) pending read ch0, flush_i[0]=1 -> next cycle rd_valid_o=1, rd_err_o=1; empty_o[0]=1; rst_i mid-PEND -> no pulse.

Source files
------------

// File: rtl/posit_result_fifo.sv
// Per-unit result FIFOs for the posit coprocessor with a single-outstanding blocking read port.
// Optional per-channel flush is enabled by defining POSIT_FIFO_FLUSH_EN.
module posit_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_CH = 3,
  localparam int CH_W  = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        push_i,
  input  logic [NUM_CH*DATA_W-1:0] push_data_i,
  input  logic                     rd_req_i,
  input  logic [CH_W-1:0]          rd_ch_i,
`ifdef POSIT_FIFO_FLUSH_EN
  input  logic [NUM_CH-1:0]        flush_i,
`endif
  output logic                     rd_valid_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_err_o,
  output logic                     rd_busy_o,
  output logic [NUM_CH-1:0]        empty_o,
  output logic [NUM_CH-1:0]        full_o,
  output logic [NUM_CH-1:0]        overflow_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic {
    RD_IDLE,
    RD_PEND
  } rd_state_e;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [NUM_CH-1:0] empty_q, full_q, ovf_q;
  logic [NUM_CH-1:0] empty_d, full_d, ovf_d;
  logic [NUM_CH-1:0] flush_w, pop, push_ok;

  rd_state_e         state_q, state_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d, sel_ch;
  logic              sel_bad, sel_empty, sel_flush, sel_pop;
  logic [DATA_W-1:0] sel_head;

  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

`ifdef POSIT_FIFO_FLUSH_EN
  assign flush_w = flush_i;
`else
  assign flush_w = '0;
`endif

  // A fresh request addresses rd_ch_i; a pending read keeps watching its latched channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_ch    = (state_q == RD_IDLE) ? rd_ch_i : pend_ch_q;
    sel_bad   = 1'b1;
    sel_empty = 1'b1;
    sel_flush = 1'b0;
    sel_head  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == CH_W'(c)) begin
        sel_bad   = 1'b0;
        sel_empty = empty_q[c];
        sel_flush = flush_w[c];
        sel_head  = mem[c][rd_ptr_q[c][IDX_W-1:0]];
      end
    end
  end

  // Read FSM next-state and completion outputs.
  always_comb begin
    state_d    = state_q;
    pend_ch_d  = pend_ch_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    rd_data_d  = '0;
    sel_pop    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_req_i) begin
          if (sel_bad || sel_flush) begin
            rd_valid_d = 1'b1;
            rd_err_d   = 1'b1;
          end else if (!sel_empty) begin
            sel_pop    = 1'b1;
            rd_valid_d = 1'b1;
            rd_data_d  = sel_head;
          end else begin
            state_d   = RD_PEND;
            pend_ch_d = rd_ch_i;
          end
        end
      end
      RD_PEND: begin
        if (sel_flush) begin
          rd_valid_d = 1'b1;
          rd_err_d   = 1'b1;
          state_d    = RD_IDLE;
        end else if (!sel_empty) begin
          sel_pop    = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = sel_head;
          state_d    = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Pointer and flag update per channel; a pop frees the slot a same-cycle push on a full channel needs.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]      = sel_pop && (sel_ch == CH_W'(c));
      push_ok[c]  = push_i[c] && (!full_q[c] || pop[c]);
      wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push_ok[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
      ovf_d[c]    = ovf_q[c] | (push_i[c] & full_q[c] & ~pop[c]);
      if (flush_w[c]) begin
        push_ok[c]  = 1'b0;
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        ovf_d[c]    = 1'b0;
      end
      empty_d[c] = (wr_ptr_d[c] == rd_ptr_d[c]);
      full_d[c]  = (wr_ptr_d[c][IDX_W-1:0] == rd_ptr_d[c][IDX_W-1:0]) &&
                   (wr_ptr_d[c][PTR_W-1] != rd_ptr_d[c][PTR_W-1]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      empty_q    <= '1;
      full_q     <= '0;
      ovf_q      <= '0;
      state_q    <= RD_IDLE;
      pend_ch_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      pend_ch_q  <= pend_ch_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok[c]) begin
        mem[c][wr_ptr_q[c][IDX_W-1:0]] <= push_data_i[c*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
  assign rd_data_o  = rd_data_q;
  assign rd_busy_o  = (state_q == RD_PEND);
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_posit_result_fifo.sv
// Self-checking bench for posit_result_fifo: vector table, scoreboard of read completions,
// and hand-written sequences for pending reads, overflow, wrap, full push+pop, flush and reset.
module tb_posit_result_fifo;

  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_CH = 3;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          push;
    int          ch;
    logic [31:0] data;
    bit          err;
  } vec_t;

  logic                 clk_i;
  logic                 rst_i;
  logic [NUM_CH-1:0]    push_i;
  logic [NUM_CH*DW-1:0] push_data_i;
  logic                 rd_req_i;
  logic [1:0]           rd_ch_i;
`ifdef POSIT_FIFO_FLUSH_EN
  logic [NUM_CH-1:0]    flush_i;
`endif
  logic                 rd_valid_o;
  logic [DW-1:0]        rd_data_o;
  logic                 rd_err_o;
  logic                 rd_busy_o;
  logic [NUM_CH-1:0]    empty_o;
  logic [NUM_CH-1:0]    full_o;
  logic [NUM_CH-1:0]    overflow_o;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  vec_t vecs[6];

  posit_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .rd_req_i    (rd_req_i),
    .rd_ch_i     (rd_ch_i),
`ifdef POSIT_FIFO_FLUSH_EN
    .flush_i     (flush_i),
`endif
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .rd_err_o    (rd_err_o),
    .rd_busy_o   (rd_busy_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .overflow_o  (overflow_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_read(input logic [31:0] d, input logic err, input int at_cyc);
    exp_t e;
    e.data = d;
    e.err  = err;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_word(input int ch, input logic [31:0] d);
    push_i = '0;
    push_i[ch] = 1'b1;
    push_data_i[ch*DW +: DW] = d;
    tick();
    push_i = '0;
  endtask

  // A hit (or error) read completes exactly one cycle after the request is sampled.
  task automatic do_read(input int ch, input bit completes, input logic [31:0] d, input logic err);
    rd_req_i = 1'b1;
    rd_ch_i  = 2'(ch);
    if (completes) expect_read(d, err, cyc + 1);
    tick();
    rd_req_i = 1'b0;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rd_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: got data 0x%08h err %0b, expected no completion (cycle %0d)",
                   rd_data_o, rd_err_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data_o, e.data);
          check("rd_err", 32'(rd_err_o), 32'(e.err));
          if (e.cyc >= 0) check("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (rd_data_o !== '0) begin
        n_err++;
        $display("FAIL idle_data: got 0x%08h, expected 0x00000000 (cycle %0d)", rd_data_o, cyc);
      end
    end
  end

  initial begin
    push_i      = '0;
    push_data_i = '0;
    rd_req_i    = 1'b0;
    rd_ch_i     = '0;
`ifdef POSIT_FIFO_FLUSH_EN
    flush_i     = '0;
`endif
    rst_i       = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    check("reset_empty", 32'(empty_o), 32'h7);
    check("reset_full", 32'(full_o), 32'h0);
    check("reset_overflow", 32'(overflow_o), 32'h0);
    check("reset_busy", 32'(rd_busy_o), 32'h0);
    check("reset_valid", 32'(rd_valid_o), 32'h0);
    check("reset_data", rd_data_o, 32'h0);

    // Table: optional push, one idle cycle, then a read of the same channel.
    vecs[0] = '{1'b1, 0, 32'h3F80_0001, 1'b0};
    vecs[1] = '{1'b1, 1, 32'hA5A5_5A5A, 1'b0};
    vecs[2] = '{1'b1, 2, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{1'b1, 0, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 3, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 2, 32'h8000_0000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].push) begin
        push_word(vecs[i].ch, vecs[i].data);
        tick();
      end
      do_read(vecs[i].ch, 1'b1, vecs[i].push ? vecs[i].data : 32'h0, vecs[i].err);
      if (vecs[i].ch < NUM_CH) check("empty_after_read", 32'(empty_o[vecs[i].ch]), 32'h1);
      else                     check("busy_after_bad_ch", 32'(rd_busy_o), 32'h0);
    end
    tick();

    // Pending read on empty ch1; a second request while pending is ignored.
    do_read(1, 1'b0, 32'h0, 1'b0);
    check("pend_busy", 32'(rd_busy_o), 32'h1);
    check("pend_no_valid", 32'(rd_valid_o), 32'h0);
    push_word(0, 32'h0000_0055);
    do_read(0, 1'b0, 32'h0, 1'b0);
    check("ignored_req_ch0_kept", 32'(empty_o[0]), 32'h0);
    check("pend_still_busy", 32'(rd_busy_o), 32'h1);
    expect_read(32'h1234_5678, 1'b0, cyc + 2);
    push_word(1, 32'h1234_5678);
    tick();
    check("pend_done_busy", 32'(rd_busy_o), 32'h0);
    do_read(0, 1'b1, 32'h0000_0055, 1'b0);

    // Fill ch2 past capacity, then drain back-to-back; contents and overflow checked.
    push_i = '0;
    push_i[2] = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      push_data_i[2*DW +: DW] = 32'(i);
      tick();
    end
    push_i = '0;
    check("ch2_full", 32'(full_o[2]), 32'h1);
    check("ch2_overflow", 32'(overflow_o[2]), 32'h1);
    check("ch0_no_overflow", 32'(overflow_o[0]), 32'h0);
    rd_req_i = 1'b1;
    rd_ch_i  = 2'd2;
    for (int i = 0; i < DEPTH; i++) begin
      expect_read(32'(i), 1'b0, cyc + 1);
      tick();
    end
    rd_req_i = 1'b0;
    check("ch2_drained_empty", 32'(empty_o[2]), 32'h1);
    check("ch2_overflow_sticky", 32'(overflow_o[2]), 32'h1);
    push_word(2, 32'hCAFE_0001);
    tick();
    do_read(2, 1'b1, 32'hCAFE_0001, 1'b0);

    // Full ch0 with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) push_word(0, 32'(100 + i));
    check("ch0_full", 32'(full_o[0]), 32'h1);
    push_i[0] = 1'b1;
    push_data_i[0 +: DW] = 32'hDEAD_BEEF;
    rd_req_i = 1'b1;
    rd_ch_i  = 2'd0;
    expect_read(32'd100, 1'b0, cyc + 1);
    tick();
    push_i   = '0;
    rd_req_i = 1'b0;
    check("ch0_pushpop_no_overflow", 32'(overflow_o[0]), 32'h0);
    check("ch0_pushpop_still_full", 32'(full_o[0]), 32'h1);
    for (int i = 1; i < DEPTH; i++) do_read(0, 1'b1, 32'(100 + i), 1'b0);
    do_read(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("ch0_final_empty", 32'(empty_o[0]), 32'h1);

`ifdef POSIT_FIFO_FLUSH_EN
    // Flush cancels a pending read with an error and clears overflow.
    do_read(0, 1'b0, 32'h0, 1'b0);
    check("flush_pend_busy", 32'(rd_busy_o), 32'h1);
    flush_i = 3'b101;
    expect_read(32'h0, 1'b1, cyc + 1);
    tick();
    flush_i = '0;
    check("flush_busy_cleared", 32'(rd_busy_o), 32'h0);
    check("flush_ch0_empty", 32'(empty_o[0]), 32'h1);
    check("flush_ch2_overflow", 32'(overflow_o[2]), 32'h0);
    tick();
`endif

    // Reset while a read is pending: dropped without a completion pulse.
    do_read(1, 1'b0, 32'h0, 1'b0);
    check("rst_pend_busy", 32'(rd_busy_o), 32'h1);
    push_word(2, 32'h0BAD_0BAD);
    rst_i = 1'b1;
    #1;
    check("rst_busy_cleared", 32'(rd_busy_o), 32'h0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check("rst_empty", 32'(empty_o), 32'h7);
    check("rst_overflow", 32'(overflow_o), 32'h0);
    check("rst_valid", 32'(rd_valid_o), 32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
